// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared status, rw, owner and state codes for the memory controller
package mem_ctrl_pkg;

    localparam int STATUS_W = 2;

    typedef enum logic [STATUS_W-1:0] {
        ST_INIT = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_status_e;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_XFER = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Byte count from the MEM-stage size field; anything other than 1 or 2 is a word.
    function automatic logic [2:0] byte_count(input logic [2:0] times);
        case (times)
            3'd1:    return 3'd1;
            3'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - MEM-stage, instruction-fetch and byte-wide RAM signals of the memory controller
interface mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_ctrl_pkg::*;

    logic [ADDR_W-1:0]   mem_addr_i;
    logic [DATA_W-1:0]   mem_data_i;
    logic [2:0]          mem_times_i;
    logic [1:0]          mem_rw_i;
    logic [DATA_W-1:0]   mem_data_o;
    logic [STATUS_W-1:0] mem_status_o;

    logic                if_req_i;
    logic [ADDR_W-1:0]   if_addr_i;
    logic [DATA_W-1:0]   if_data_o;
    logic [STATUS_W-1:0] if_status_o;

    logic [7:0]          ram_din;
    logic [7:0]          ram_dout;
    logic [ADDR_W-1:0]   ram_a;
    logic                ram_wr;

    modport slave (
        input  mem_addr_i, mem_data_i, mem_times_i, mem_rw_i, if_req_i, if_addr_i, ram_din,
        output mem_data_o, mem_status_o, if_data_o, if_status_o, ram_dout, ram_a, ram_wr
    );

    modport master (
        output mem_addr_i, mem_data_i, mem_times_i, mem_rw_i, if_req_i, if_addr_i, ram_din,
        input  mem_data_o, mem_status_o, if_data_o, if_status_o, ram_dout, ram_a, ram_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - serialises 1/2/4-byte IF/MEM requests onto a byte-wide 1-cycle-latency RAM
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          k_q, k_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [STATUS_W-1:0] mem_status_q, mem_status_d;
    logic [STATUS_W-1:0] if_status_q, if_status_d;

    logic       finish;
    logic [1:0] lane;
    logic [1:0] last_idx;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        n_d          = n_q;
        k_d          = k_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf_d        = buf_q;
        mem_data_d   = mem_data_q;
        if_data_d    = if_data_q;
        mem_status_d = mem_status_q;
        if_status_d  = if_status_q;
        finish       = 1'b0;
        lane         = k_q[1:0] - 2'd1;
        last_idx     = 2'(n_q - 3'd1);
        bus.ram_wr   = 1'b0;
        bus.ram_a    = '0;
        bus.ram_dout = '0;

        case (state_q)
            S_IDLE: begin
                // MEM outranks IF; only one requester is ever latched.
                if (bus.mem_rw_i != RW_IDLE) begin
                    owner_d      = OWN_MEM;
                    wr_d         = (bus.mem_rw_i == RW_WRITE);
                    n_d          = byte_count(bus.mem_times_i);
                    addr_d       = bus.mem_addr_i;
                    wdata_d      = bus.mem_data_i;
                    mem_status_d = ST_BUSY;
                    k_d          = '0;
                    buf_d        = '0;
                    state_d      = S_XFER;
                end else if (bus.if_req_i) begin
                    owner_d      = OWN_IF;
                    wr_d         = 1'b0;
                    n_d          = 3'd4;
                    addr_d       = bus.if_addr_i;
                    wdata_d      = '0;
                    if_status_d  = ST_BUSY;
                    k_d          = '0;
                    buf_d        = '0;
                    state_d      = S_XFER;
                end
            end

            S_XFER: begin
                // On a read the address bus parks on the last byte while its data returns.
                bus.ram_a = addr_q + ADDR_W'((k_q == n_q) ? last_idx : k_q[1:0]);
                k_d       = k_q + 3'd1;
                if (wr_q) begin
                    bus.ram_wr   = 1'b1;
                    bus.ram_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
                    finish       = (k_q == n_q - 3'd1);
                end else begin
                    if (k_q != 3'd0) begin
                        buf_d[{lane, 3'b000} +: 8] = bus.ram_din;
                    end
                    finish = (k_q == n_q);
                end
                if (finish) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_status_d = ST_DONE;
                        if (!wr_q) begin
                            mem_data_d = buf_d;
                        end
                    end else begin
                        if_status_d = ST_DONE;
                        if_data_d   = buf_d;
                    end
                end
            end

            S_DONE: begin
                mem_status_d = ST_INIT;
                if_status_d  = ST_INIT;
                state_d      = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            wr_q         <= 1'b0;
            n_q          <= '0;
            k_q          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf_q        <= '0;
            mem_data_q   <= '0;
            if_data_q    <= '0;
            mem_status_q <= ST_INIT;
            if_status_q  <= ST_INIT;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            n_q          <= n_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf_q        <= buf_d;
            mem_data_q   <= mem_data_d;
            if_data_q    <= if_data_d;
            mem_status_q <= mem_status_d;
            if_status_q  <= if_status_d;
        end
    end

    assign bus.mem_data_o   = mem_data_q;
    assign bus.if_data_o    = if_data_q;
    assign bus.mem_status_o = mem_status_q;
    assign bus.if_status_o  = if_status_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

- Memory controller; the responder end of the MEM-stage and instruction-fetch request interfaces.
- Serialises 1/2/4-byte read/write requests onto the byte-wide, 1-cycle-latency RAM port.
- Reports progress through a registered status code that the requester samples combinationally.
- Sits between the pipeline (IF, MEM stages) and the RAM/IO bus; one transaction in flight at a time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, word width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- mem_addr_i  in  32  MEM-stage byte address
- mem_data_i  in  32  MEM-stage store data; byte i = bits [8i+7:8i]
- mem_times_i  in  3  byte count; legal values 1, 2, 4
- mem_rw_i  in  2  00 idle, 01 read, 10 write
- mem_data_o  out  32  load data, zero-extended, little-endian
- mem_status_o  out  2  Init 00, Busy 01, Done 10
- if_req_i  in  1  IF word-read request
- if_addr_i  in  32  IF address
- if_data_o  out  32  fetched word
- if_status_o  out  2  same encoding as mem_status_o
- ram_din  in  8  byte returned by RAM, one cycle after its address
- ram_dout  out  8  write byte
- ram_a  out  32  RAM address
- ram_wr  out  1  1 = write, 0 = read

## Operation
- States: IDLE, XFER, DONE.
- **IDLE**: arbitrate.
  - MEM (mem_rw_i ≠ 00) beats IF.
  - Latch owner, addr, data, rw and count n (mem_times 1→1, 2→2, anything else→4; IF always 4).
  - Owner's status goes Busy; enter XFER.
- **XFER**: byte index k runs 0..n-1.
  - ram_a = base+k on cycle k+1 after acceptance.
  - Write: ram_wr=1 and ram_dout = byte k in the same cycle.
  - Read: ram_wr=0; ram_din captured into byte lane k on the following cycle.
  - Read capture of the last byte occurs after the address phase ends. ram_a holds the last address and ram_wr=0 during that extra cycle.
- **DONE**: owner's status = Done for exactly one cycle.
  - Data output is valid and held until the next Done for that port.
  - Requests are ignored in DONE; return to IDLE next cycle.
- The non-owner port reads Init throughout. Arbitration is non-preemptive.
- Requester inputs are sampled only in IDLE. Changes during XFER/DONE are ignored.
- Outside XFER: ram_wr=0, ram_a=0, ram_dout=0.
- Read unused upper bytes are 0. Sign extension is the requester's job.
- Status outputs come only from flops, so there is no combinational path from mem_rw_i to mem_status_o.

## Timing
- Cycle 0 = request visible in IDLE.
- Read of n bytes:
  - Addresses on cycles 1..n.
  - Data on ram_din on cycles 2..n+1.
  - Done on cycle n+2.
  - Busy on cycles 1..n+1.
- Write of n bytes: writes on cycles 1..n; Done on cycle n+1.
- Earliest next acceptance is the cycle after Done.
- IF word fetch: Done on cycle 6. MEM byte load: Done on cycle 3. MEM word store: Done on cycle 5.
- Simultaneous IF+MEM in IDLE: MEM is served. IF sees Init, then is accepted in the IDLE cycle after MEM's Done.
- Reset on any edge:
  - State → IDLE.
  - All outputs 0, both statuses Init, ram_wr=0 from the next cycle.
  - In-flight transaction is dropped, including a partially written store.

## Structure
- Shared package/config header holds:
  - MemStatus width (2) with Init/Busy/Done codes.
  - RW codes (idle/read/write).
  - Owner codes (IF/MEM).
- Single module; FSM, byte counter and lane-assembly register inline.
- A separate arbiter sub-module is not warranted.

## Test plan
- **MEM LW** at 0x100, RAM bytes 11,22,33,44:
  - ram_a 0x100..0x103 on cycles 1..4.
  - mem_data_o=0x44332211 with Done on cycle 6.
  - Busy on cycles 1..5.
- **MEM SH** 0x0000ABCD to 0x20:
  - ram_wr=1, ram_a 0x20/0x21, ram_dout CD then AB on cycles 1–2.
  - Done on cycle 3; ram_wr=0 afterwards.
- **MEM LB** at 0x7, RAM byte 0x80:
  - mem_data_o=0x00000080, Done on cycle 3.
- **IF and MEM SB raised together**:
  - SB served first, Done on cycle 2; if_status Init meanwhile.
  - IF accepted on cycle 3; if_status Done on cycle 9.
- **Reset asserted during cycle 2 of SW**:
  - ram_wr=0 and both statuses Init on the next cycle.
  - Only bytes 0–1 written.
  - A fresh LW afterwards completes normally.
- **Requester holds mem_rw_i=01 through Done, then drops to 00**:
  - Exactly one Done pulse.
  - No second transaction started.
